// File: rtl/seven_segment_capture.sv
// Receive-side monitor for a multiplexed 7-segment bus: qualifies and decodes digits.
// Define SEVEN_CAPTURE_BLANK_EN to treat an all-off pattern as a blank digit.
module seven_segment_capture #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_DIGITS-1:0]   seven_enable,
   input  logic                    A,
   input  logic                    B,
   input  logic                    C,
   input  logic                    D,
   input  logic                    E,
   input  logic                    F,
   input  logic                    G,
   output logic [4*NUM_DIGITS-1:0] digit_value,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    update,
   output logic [1:0]              update_idx,
   output logic                    error,
   output logic [6:0]              error_pattern
);

   localparam int SW = NUM_DIGITS + 7;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT   = 2'd0,
      SETTLE = 2'd1,
      HELD   = 2'd2
   } state_t;

   state_t           state_q;
   logic [SW-1:0]    s_q;
   logic [SW-1:0]    p_q;
   logic [CNT_W-1:0] cnt_q;

   logic [NUM_DIGITS-1:0] en;
   logic [6:0]            seg;
   logic                  same;
   logic                  onehot;
   logic [1:0]            idx;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  accept;
   logic                  dec_ok;
   logic [3:0]            dec_val;
   logic                  blank;

   assign en   = s_q[SW-1:7];
   assign seg  = s_q[6:0];
   assign same = (s_q == p_q);

   // Only a single low enable line identifies a driven digit.
   always_comb begin
      onehot = 1'b1;
      idx    = 2'd0;
      case (en)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: onehot = 1'b0;
      endcase
   end

   always_comb begin
      dec_ok  = 1'b1;
      dec_val = 4'h0;
      case (seg)
         7'b0000001: dec_val = 4'h0;
         7'b1001111: dec_val = 4'h1;
         7'b0010010: dec_val = 4'h2;
         7'b0000110: dec_val = 4'h3;
         7'b1001100: dec_val = 4'h4;
         7'b0100100: dec_val = 4'h5;
         7'b0100000: dec_val = 4'h6;
         7'b0001111: dec_val = 4'h7;
         7'b0000000: dec_val = 4'h8;
         7'b0001100: dec_val = 4'h9;
         7'b0001000: dec_val = 4'hA;
         7'b1100000: dec_val = 4'hB;
         7'b0110001: dec_val = 4'hC;
         7'b1000010: dec_val = 4'hD;
         7'b0110000: dec_val = 4'hE;
         7'b0111000: dec_val = 4'hF;
         default:    dec_ok  = 1'b0;
      endcase
   end

`ifdef SEVEN_CAPTURE_BLANK_EN
   assign blank = (seg == 7'h7F);
`else
   assign blank = 1'b0;
`endif

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
   assign accept  = same && (state_q == SETTLE) &&
                    (cnt_inc == CNT_MAX) && onehot;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s_q           <= '1;
         p_q           <= '1;
         cnt_q         <= '0;
         state_q       <= WAIT;
         digit_value   <= '0;
         digit_valid   <= '0;
         update        <= 1'b0;
         update_idx    <= 2'd0;
         error         <= 1'b0;
         error_pattern <= 7'h7F;
      end else begin
         s_q    <= {seven_enable, A, B, C, D, E, F, G};
         p_q    <= s_q;
         update <= 1'b0;
         error  <= 1'b0;
         if (!same) begin
            cnt_q   <= '0;
            state_q <= onehot ? SETTLE : WAIT;
         end else begin
            cnt_q <= cnt_inc;
            case (state_q)
               WAIT: begin
                  if (onehot) state_q <= SETTLE;
               end
               SETTLE: begin
                  if (!onehot) begin
                     state_q <= WAIT;
                  end else if (accept) begin
                     state_q    <= HELD;
                     update_idx <= idx;
                     if (blank) begin
                        digit_valid[idx] <= 1'b0;
                        update           <= 1'b1;
                     end else if (dec_ok) begin
                        digit_value[4*idx +: 4] <= dec_val;
                        digit_valid[idx]        <= 1'b1;
                        update                  <= 1'b1;
                     end else begin
                        digit_valid[idx] <= 1'b0;
                        error            <= 1'b1;
                        error_pattern    <= seg;
                     end
                  end
               end
               HELD: begin
                  if (!onehot) state_q <= WAIT;
               end
               default: state_q <= WAIT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture: run-length reference model,
// expected events queued by the driver and popped by a negedge monitor.
module tb_seven_segment_capture;

   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  seven_enable = 4'hF;
   logic        A = 1, B = 1, C = 1, D = 1, E = 1, F = 1, G = 1;
   logic [15:0] digit_value;
   logic [3:0]  digit_valid;
   logic        update;
   logic [1:0]  update_idx;
   logic        error;
   logic [6:0]  error_pattern;

   seven_segment_capture dut (
      .clk(clk), .reset_n(reset_n), .seven_enable(seven_enable),
      .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
      .digit_value(digit_value), .digit_valid(digit_valid),
      .update(update), .update_idx(update_idx), .error(error),
      .error_pattern(error_pattern)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         edge_n;
      bit         is_err;
      logic [1:0] idx;
      logic [6:0] pat;
      logic [15:0] val;
      logic [3:0] vld;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;
   int edge_n = 0;
   int mcyc = 0;

   logic [6:0] pats [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   logic [10:0] last;
   int          run;
   bit          pending;
   logic [3:0]  mval [4];
   bit          mvld [4];
   logic [6:0]  merr;

   function automatic int lookup(logic [6:0] p);
      for (int i = 0; i < 16; i++)
         if (pats[i] == p) return i;
      return -1;
   endfunction

   function automatic int onehot_idx(logic [3:0] e);
      int n = 0;
      int k = -1;
      for (int i = 0; i < 4; i++)
         if (!e[i]) begin n++; k = i; end
      return (n == 1) ? k : -1;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] pack_val();
      logic [15:0] v;
      for (int i = 0; i < 4; i++) v[4*i +: 4] = mval[i];
      return v;
   endfunction

   function automatic logic [3:0] pack_vld();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = mvld[i];
      return v;
   endfunction

   task automatic model_edge(bit rst, logic [10:0] v);
      exp_t x;
      int   id;
      int   k;
      if (rst) begin
         last = 11'h7FF; run = 1; pending = 0; merr = 7'h7F;
         for (int i = 0; i < 4; i++) begin mval[i] = 0; mvld[i] = 0; end
         return;
      end
      if (pending) begin
         id = onehot_idx(last[10:7]);
         k  = lookup(last[6:0]);
         x.is_err = 0;
`ifdef SEVEN_CAPTURE_BLANK_EN
         if (last[6:0] == 7'h7F) mvld[id] = 0;
         else
`endif
         if (k >= 0) begin
            mval[id] = 4'(k);
            mvld[id] = 1;
         end else begin
            merr = last[6:0];
            mvld[id] = 0;
            x.is_err = 1;
         end
         x.edge_n = edge_n;
         x.idx = 2'(id);
         x.pat = merr;
         x.val = pack_val();
         x.vld = pack_vld();
         q.push_back(x);
      end
      if (v == last) run++;
      else begin last = v; run = 1; end
      pending = (run == SC) && (onehot_idx(v[10:7]) >= 0);
   endtask

   task automatic step(bit rst, logic [3:0] en, logic [6:0] seg);
      reset_n = !rst;
      seven_enable = en;
      {A, B, C, D, E, F, G} = seg;
      @(posedge clk);
      edge_n++;
      model_edge(rst, {en, seg});
      @(negedge clk);
   endtask

   task automatic hold(int n, logic [3:0] en, logic [6:0] seg);
      for (int i = 0; i < n; i++) step(0, en, seg);
   endtask

   task automatic check_reset_vals();
      chk("rst_value", 32'(digit_value), 32'h0);
      chk("rst_valid", 32'(digit_valid), 32'h0);
      chk("rst_update", 32'(update), 32'h0);
      chk("rst_error", 32'(error), 32'h0);
      chk("rst_idx", 32'(update_idx), 32'h0);
      chk("rst_pattern", 32'(error_pattern), 32'h7F);
   endtask

   always @(negedge clk) begin
      exp_t x;
      mcyc++;
      if (update || error) begin
         chk("exclusive", 32'(update & error), 32'h0);
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event update=%0b error=%0b idx=%0d cycle=%0d required=none",
                     update, error, update_idx, mcyc);
         end else begin
            x = q.pop_front();
            chk("ev_cycle", 32'(mcyc), 32'(x.edge_n));
            chk("ev_update", 32'(update), 32'(!x.is_err));
            chk("ev_error", 32'(error), 32'(x.is_err));
            chk("ev_idx", 32'(update_idx), 32'(x.idx));
            chk("ev_pattern", 32'(error_pattern), 32'(x.pat));
            chk("ev_value", 32'(digit_value), 32'(x.val));
            chk("ev_valid", 32'(digit_valid), 32'(x.vld));
         end
      end
   end

   initial begin
      logic [3:0] en;
      logic [6:0] seg;
      step(1, 4'hF, 7'h7F);
      step(1, 4'hF, 7'h7F);
      check_reset_vals();

      hold(6, 4'b1110, 7'b0000001);
      hold(6, 4'b1110, pats[1]);
      hold(6, 4'b1101, pats[2]);
      hold(6, 4'b1011, pats[3]);
      hold(6, 4'b0111, pats[15]);
      chk("scan_value", 32'(digit_value), 32'hF321);
      chk("scan_valid", 32'(digit_valid), 32'hF);

      hold(6, 4'b1011, 7'b1111110);
      chk("err_valid", 32'(digit_valid), 32'b1011);
      chk("err_pattern", 32'(error_pattern), 32'h7E);

      for (int i = 0; i < 6; i++)
         hold(3, 4'b1110, pats[4 + (i % 2)]);
      hold(10, 4'b1100, pats[8]);

      hold(2, 4'b1101, pats[2]);
      step(1, 4'b1101, pats[2]);
      check_reset_vals();
      hold(6, 4'b1101, pats[2]);

      hold(6, 4'b0111, 7'h7F);

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) < 8) begin
            en = 4'hF;
            en[$urandom_range(0, 3)] = 1'b0;
         end else begin
            en = 4'($urandom);
         end
         if ($urandom_range(0, 3) != 0) seg = pats[$urandom_range(0, 15)];
         else seg = 7'($urandom);
         if ($urandom_range(0, 49) == 0) step(1, en, seg);
         hold($urandom_range(1, 7), en, seg);
      end

      hold(8, 4'hF, 7'h7F);
      chk("queue_empty", 32'(q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
